// File: rtl/trap_pkg.sv
// Shared types and helpers for the trapezoidal filter configuration sequencer.
package trap_pkg;

  localparam int unsigned DELAY_WIDTH = 14;
  localparam int unsigned MIN_K       = 3;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } trap_state_e;

  function automatic int unsigned settle_len(input int unsigned k,
                                             input int unsigned l,
                                             input int unsigned extra);
    return k + l + extra;
  endfunction

endpackage

// File: rtl/trap_settle_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
module trap_settle_counter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= WIDTH'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/trap_sequencer.sv
// Validates and atomically applies trapezoid filter settings, sequences the
// filter reset/fill period, and gates filter output until it is trustworthy.
module trap_sequencer #(
  parameter int unsigned       AXIS_TDATA_WIDTH = 16,
  parameter int unsigned       DELAY_WIDTH      = trap_pkg::DELAY_WIDTH,
  parameter int unsigned       MIN_K            = trap_pkg::MIN_K,
  parameter int unsigned       FLUSH_CYCLES     = 4,
  parameter int unsigned       SETTLE_EXTRA     = 8,
  parameter int unsigned       DEF_K            = 100,
  parameter int unsigned       DEF_L            = 200,
  parameter logic signed [15:0] DEF_MULT        = 16'sd1000
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [DELAY_WIDTH-1:0]               cfg_k,
  input  logic [DELAY_WIDTH-1:0]               cfg_l,
  input  logic signed [15:0]                   cfg_mult,
  input  logic                                 cfg_commit,
  output logic                                 cfg_busy,
  output logic                                 cfg_err,
  output logic                                 trap_aresetn,
  output logic [DELAY_WIDTH-1:0]               trap_kdelay,
  output logic [DELAY_WIDTH-1:0]               trap_ldelay,
  output logic signed [15:0]                   trap_mult,
  input  logic signed [2*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic signed [2*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid
);

  import trap_pkg::trap_state_e;
  import trap_pkg::FLUSH;
  import trap_pkg::SETTLE;
  import trap_pkg::RUN;
  import trap_pkg::settle_len;

  localparam int unsigned CW = DELAY_WIDTH + 2;

  trap_state_e state_q, state_d;
  logic [DELAY_WIDTH-1:0]               k_q, k_d, l_q, l_d;
  logic signed [15:0]                   mult_q, mult_d;
  logic                                 err_q, err_d;
  logic                                 rstn_q, rstn_d;
  logic                                 mvalid_q, mvalid_d;
  logic signed [2*AXIS_TDATA_WIDTH-1:0] mdata_q, mdata_d;
  logic                                 commit_ok;
  logic                                 cnt_load;
  logic [CW-1:0]                        cnt_load_val;
  logic                                 cnt_tc;

  // Reset value is one more than a commit load: the first edge after reset
  // release plays the role of the commit edge.
  trap_settle_counter #(
    .WIDTH   (CW),
    .RST_VAL (FLUSH_CYCLES)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (aresetn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    commit_ok = cfg_commit && (cfg_k >= DELAY_WIDTH'(MIN_K)) &&
                (cfg_l >= cfg_k) && (cfg_mult != '0);
    state_d      = state_q;
    k_d          = k_q;
    l_d          = l_q;
    mult_d       = mult_q;
    err_d        = err_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (cfg_commit) begin
      err_d = !commit_ok;
    end
    if (commit_ok) begin
      state_d      = FLUSH;
      k_d          = cfg_k;
      l_d          = cfg_l;
      mult_d       = cfg_mult;
      cnt_load     = 1'b1;
      cnt_load_val = CW'(FLUSH_CYCLES - 1);
    end else begin
      case (state_q)
        FLUSH: begin
          if (cnt_tc) begin
            state_d      = SETTLE;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(settle_len(32'(k_q), 32'(l_q), SETTLE_EXTRA) - 1);
          end
        end
        SETTLE: begin
          if (cnt_tc) begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
    // Keyed off the next state so the gate closes on the same edge the filter reset falls.
    rstn_d   = (state_d != FLUSH);
    mvalid_d = (state_d == RUN) ? s_axis_tvalid : 1'b0;
    mdata_d  = (state_d == RUN) ? s_axis_tdata : '0;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= FLUSH;
      k_q      <= DELAY_WIDTH'(DEF_K);
      l_q      <= DELAY_WIDTH'(DEF_L);
      mult_q   <= DEF_MULT;
      err_q    <= 1'b0;
      rstn_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      l_q      <= l_d;
      mult_q   <= mult_d;
      err_q    <= err_d;
      rstn_q   <= rstn_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
    end
  end

  assign cfg_busy      = (state_q != RUN);
  assign cfg_err       = err_q;
  assign trap_aresetn  = rstn_q;
  assign trap_kdelay   = k_q;
  assign trap_ldelay   = l_q;
  assign trap_mult     = mult_q;
  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvalid_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: reset timeline, commits, rejects, restarts, max delays.
module tb_trap_sequencer;

  logic               clk = 1'b0;
  logic               aresetn;
  logic [13:0]        cfg_k, cfg_l;
  logic signed [15:0] cfg_mult;
  logic               cfg_commit;
  logic               cfg_busy, cfg_err, trap_aresetn;
  logic [13:0]        trap_kdelay, trap_ldelay;
  logic signed [15:0] trap_mult;
  logic signed [31:0] s_axis_tdata, m_axis_tdata;
  logic               s_axis_tvalid, m_axis_tvalid;

  logic [31:0] prev_d;
  logic        prev_v;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  trap_sequencer #(
    .FLUSH_CYCLES (4),
    .SETTLE_EXTRA (8)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .cfg_k         (cfg_k),
    .cfg_l         (cfg_l),
    .cfg_mult      (cfg_mult),
    .cfg_commit    (cfg_commit),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .trap_aresetn  (trap_aresetn),
    .trap_kdelay   (trap_kdelay),
    .trap_ldelay   (trap_ldelay),
    .trap_mult     (trap_mult),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: remember what was presented, advance past the edge, present a new sample.
  task automatic tick();
    prev_d = s_axis_tdata;
    prev_v = s_axis_tvalid;
    @(posedge clk);
    #1;
    s_axis_tdata  = $urandom;
    s_axis_tvalid = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic commit(input logic [13:0] k, input logic [13:0] l, input logic [15:0] m);
    cfg_k      = k;
    cfg_l      = l;
    cfg_mult   = m;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rstn"},  32'(trap_aresetn), 32'd0);
    chk({tag, "_busy"},  32'(cfg_busy), 32'd1);
    chk({tag, "_err"},   32'(cfg_err), 32'd0);
    chk({tag, "_k"},     32'(trap_kdelay), 32'd100);
    chk({tag, "_l"},     32'(trap_ldelay), 32'd200);
    chk({tag, "_mult"},  {16'h0, trap_mult}, 32'd1000);
    chk({tag, "_mvld"},  32'(m_axis_tvalid), 32'd0);
    chk({tag, "_mdata"}, m_axis_tdata, 32'd0);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_mvld"},  32'(m_axis_tvalid), 32'(prev_v));
    chk({tag, "_mdata"}, m_axis_tdata, prev_d);
  endtask

  initial begin
    aresetn       = 1'b0;
    cfg_k         = '0;
    cfg_l         = '0;
    cfg_mult      = '0;
    cfg_commit    = 1'b0;
    s_axis_tdata  = 32'h1234_5678;
    s_axis_tvalid = 1'b1;
    prev_d        = '0;
    prev_v        = 1'b0;

    // Reset values, then default timeline from the first edge after release.
    #12;
    chk_reset_vals("por");
    aresetn = 1'b1;
    ticks(4);
    chk("por_flush_end", 32'(trap_aresetn), 32'd0);
    chk("por_flush_mvld", 32'(m_axis_tvalid), 32'd0);
    tick();
    chk("por_settle", 32'(trap_aresetn), 32'd1);
    ticks(307);
    chk("por_busy_311", 32'(cfg_busy), 32'd1);
    chk("por_mvld_311", 32'(m_axis_tvalid), 32'd0);
    tick();
    chk("por_run_312", 32'(cfg_busy), 32'd0);
    chk_stream("por_first");
    tick();
    chk_stream("por_second");

    // Valid commit from RUN.
    commit(14'd10, 14'd20, 16'd500);
    chk("c1_mvld", 32'(m_axis_tvalid), 32'd0);
    chk("c1_mdata", m_axis_tdata, 32'd0);
    chk("c1_rstn", 32'(trap_aresetn), 32'd0);
    chk("c1_busy", 32'(cfg_busy), 32'd1);
    chk("c1_k", 32'(trap_kdelay), 32'd10);
    chk("c1_l", 32'(trap_ldelay), 32'd20);
    chk("c1_mult", {16'h0, trap_mult}, 32'd500);
    ticks(3);
    chk("c1_rstn_t3", 32'(trap_aresetn), 32'd0);
    tick();
    chk("c1_rstn_t4", 32'(trap_aresetn), 32'd1);
    ticks(37);
    chk("c1_busy_t41", 32'(cfg_busy), 32'd1);
    tick();
    chk("c1_run_t42", 32'(cfg_busy), 32'd0);
    chk_stream("c1_run");

    // Rejected commits leave config and RUN stream untouched.
    commit(14'd2, 14'd20, 16'd5);
    chk("bad_k_err", 32'(cfg_err), 32'd1);
    chk("bad_k_k", 32'(trap_kdelay), 32'd10);
    chk_stream("bad_k");
    commit(14'd30, 14'd20, 16'd5);
    chk("bad_l_k", 32'(trap_kdelay), 32'd10);
    chk("bad_l_l", 32'(trap_ldelay), 32'd20);
    chk("bad_l_busy", 32'(cfg_busy), 32'd0);
    commit(14'd10, 14'd20, 16'd0);
    chk("bad_m_err", 32'(cfg_err), 32'd1);
    chk("bad_m_mult", {16'h0, trap_mult}, 32'd500);
    chk_stream("bad_m");

    // Restart from SETTLE; equal K and L is legal.
    commit(14'd40, 14'd50, 16'd7);
    chk("rs_err_clr", 32'(cfg_err), 32'd0);
    chk("rs_k1", 32'(trap_kdelay), 32'd40);
    ticks(19);
    chk("rs_settle", 32'(trap_aresetn), 32'd1);
    commit(14'd5, 14'd5, 16'd9);
    chk("rs_rstn", 32'(trap_aresetn), 32'd0);
    chk("rs_k2", 32'(trap_kdelay), 32'd5);
    chk("rs_mult2", {16'h0, trap_mult}, 32'd9);
    ticks(4);
    chk("rs_rstn_t24", 32'(trap_aresetn), 32'd1);
    ticks(17);
    chk("rs_busy_t41", 32'(cfg_busy), 32'd1);
    tick();
    chk("rs_run_t42", 32'(cfg_busy), 32'd0);

    // Smallest legal K.
    commit(14'd3, 14'd3, 16'd1);
    chk("mink_err", 32'(cfg_err), 32'd0);
    chk("mink_k", 32'(trap_kdelay), 32'd3);
    ticks(17);
    chk("mink_busy_t17", 32'(cfg_busy), 32'd1);
    tick();
    chk("mink_run_t18", 32'(cfg_busy), 32'd0);

    // Reject during SETTLE, then async reset mid-settle.
    commit(14'd10, 14'd20, 16'd500);
    ticks(5);
    commit(14'd1, 14'd20, 16'd5);
    chk("ms_err", 32'(cfg_err), 32'd1);
    chk("ms_rstn", 32'(trap_aresetn), 32'd1);
    ticks(5);
    aresetn = 1'b0;
    #1;
    chk_reset_vals("mid");
    #1;
    aresetn = 1'b1;
    ticks(4);
    chk("mid_flush_end", 32'(trap_aresetn), 32'd0);
    tick();
    chk("mid_settle", 32'(trap_aresetn), 32'd1);
    ticks(307);
    chk("mid_busy_311", 32'(cfg_busy), 32'd1);
    tick();
    chk("mid_run_312", 32'(cfg_busy), 32'd0);

    // Maximum delays must not wrap the counter.
    commit(14'd16383, 14'd16383, 16'd1);
    chk("max_k", 32'(trap_kdelay), 32'd16383);
    ticks(32777);
    chk("max_busy", 32'(cfg_busy), 32'd1);
    chk("max_mvld", 32'(m_axis_tvalid), 32'd0);
    tick();
    chk("max_run", 32'(cfg_busy), 32'd0);
    chk_stream("max_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Configuration and start-up sequencer for the trapezoidal shaping filter. It takes K/L/multiplier settings from the PS register bank, validates them, and applies them atomically. On each apply it holds the filter in reset, releases it, and waits out the ring-buffer fill and arithmetic pipeline. Filter output is forwarded downstream only once that output is trustworthy. It sits between the register bank and the filter instance, and between the filter output and the DAC/DMA path.

## Interface
Parameters:
- AXIS_TDATA_WIDTH, 16: filter input sample width; filter output is 2*AXIS_TDATA_WIDTH.
- DELAY_WIDTH, 14: width of K and L delays.
- MIN_K, 3: smallest legal K.
- FLUSH_CYCLES, 4: cycles the filter reset is held low per apply (≥1).
- SETTLE_EXTRA, 8: cycles added to K+L to cover filter enable and arithmetic pipeline.
- DEF_K, 100 / DEF_L, 200 / DEF_MULT, 16'sd1000: configuration active after reset.

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous, active-low reset.
- cfg_k  in  DELAY_WIDTH  requested rise/fall length.
- cfg_l  in  DELAY_WIDTH  requested L delay.
- cfg_mult  in  16 signed  requested decay multiplier.
- cfg_commit  in  1  single-cycle apply strobe.
- cfg_busy  out  1  high whenever state ≠ RUN.
- cfg_err  out  1  sticky; set by a rejected commit, cleared by an accepted commit.
- trap_aresetn  out  1  registered reset to the filter.
- trap_kdelay  out  DELAY_WIDTH  active K.
- trap_ldelay  out  DELAY_WIDTH  active L.
- trap_mult  out  16 signed  active multiplier.
- s_axis_tdata  in  2*AXIS_TDATA_WIDTH signed  filter output.
- s_axis_tvalid  in  1  filter output valid.
- m_axis_tdata  out  2*AXIS_TDATA_WIDTH signed  gated output.
- m_axis_tvalid  out  1  gated valid.

## Operation
- States:
  - FLUSH: trap_aresetn=0, count FLUSH_CYCLES.
  - SETTLE: trap_aresetn=1, count K+L+SETTLE_EXTRA.
  - RUN: output forwarded.
- Reset values: state=FLUSH, counter=0, active config = DEF_*, trap_aresetn=0, cfg_busy=1, cfg_err=0, m_axis_tvalid=0, m_axis_tdata=0.
- Transitions:
  - FLUSH→SETTLE when FLUSH_CYCLES cycles have elapsed.
  - SETTLE→RUN when K+L+SETTLE_EXTRA cycles have elapsed.
  - RUN holds until a commit.
- Commit validity: cfg_k ≥ MIN_K, cfg_l ≥ cfg_k, cfg_mult ≠ 0.
- Valid commit, in any state: latch cfg_* into active registers, clear cfg_err, enter FLUSH with counter=0. A commit during FLUSH or SETTLE restarts the sequence.
- Invalid commit: set cfg_err; active config, state and counter are unchanged; RUN continues uninterrupted.
- Settle counting is cycle-based and ignores s_axis_tvalid, because the filter's own fill logic is cycle-based.
- Counter width is DELAY_WIDTH+2 bits; K+L+SETTLE_EXTRA must never wrap. A maximum K=L=16383 needs 32774 cycles.
- Gating: in RUN, m_axis_tdata/m_axis_tvalid register s_axis_tdata/s_axis_tvalid. Outside RUN both register 0.
- Active config outputs change only on an accepted commit. They are registered and stable through FLUSH, so the filter samples new delays while held in reset.
- Reset asserted mid-sequence returns to FLUSH with DEF_* config. An accepted commit from before the reset is lost.

## Timing
- Accepted commit sampled at edge t:
  - At t+1: state=FLUSH, trap_aresetn=0, new config on trap_* outputs, cfg_busy=1, m_axis_tvalid=0.
  - At t+FLUSH_CYCLES+1: trap_aresetn=1, state=SETTLE.
  - At t+FLUSH_CYCLES+K+L+SETTLE_EXTRA+1: state=RUN, cfg_busy=0.
- After reset deassertion, the same timeline applies with t = the first clk edge after aresetn rises.
- Datapath latency in RUN: 1 cycle from s_axis to m_axis.
- At the FLUSH entry edge, m_axis_tvalid drops to 0 in the same cycle trap_aresetn falls. No filter reset-transient sample is ever forwarded.
- cfg_err updates at t+1 for both accepted and rejected commits.

## Structure
- Package trap_pkg holds:
  - the state enum {FLUSH, SETTLE, RUN};
  - DELAY_WIDTH and MIN_K constants;
  - a function computing settle length (K+L+SETTLE_EXTRA).
- Sub-module trap_settle_counter: loadable down-counter with a terminal-count output, reused by FLUSH and SETTLE. Everything else is inline FSM logic.

## Test plan
Common setup: FLUSH_CYCLES=4, SETTLE_EXTRA=8, filter model attached.
- Reset release → trap_aresetn rises 4 cycles after the first edge; RUN and cfg_busy=0 at cycle 4+100+200+8+1=313; trap_kdelay=100, trap_ldelay=200.
- Commit K=10, L=20, M=500 while in RUN → m_axis_tvalid=0 at t+1, trap_aresetn low t+1..t+4, RUN at t+43; the step input then produces a correct trapezoid with flat top L−K=10.
- Commit K=2, then K=30/L=20, then M=0 → each sets cfg_err=1; trap_* unchanged; m_axis stream uninterrupted in RUN.
- Valid commit at t, second valid commit K=5/L=5 at t+20 (in SETTLE) → FLUSH restarts at t+21; RUN at t+20+4+5+5+8+1=t+43; first commit's config never reaches RUN.
- aresetn pulsed low at SETTLE count 7 → all outputs return to reset values immediately; full DEF_* sequence reruns.
- K=L=16383 → RUN exactly 4+32766+8+1 cycles after commit; no counter wrap.
